scanlines_ext: RTL

Parametrised scanline darkening stage for the video output path, placed after the scaler/shifter and before the DAC/HDMI encoder. It dims one line in every N (N = 2, 3 or 4) by a selectable amount. Colour width is configurable, and the dimmed line phase can be chosen. Configuration is double-buffered and only takes effect at frame start, so changing settings mid-frame cannot cause tearing. Syncs, DE and colour leave the block together, one pixel-enable later than they enter.

---
 rtl/scanlines_ext.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/scanlines_ext.sv
// Scanline darkening stage: dims one video line in every N (2/3/4) by 25/50/75%.
// Latency: exactly one ce_pix for hs/vs/de and colour; outputs keep input sync polarity.
// Backpressure: none; the stage free-runs on ce_pix and holds all state while it is low.
//
// Ports:
//   clk_sys, reset          system clock, synchronous active-high reset
//   ce_pix                  pixel clock enable
//   scanlines/period/phase  live config, sampled into shadow regs at vsync leading edge
//   hs_in/vs_in/de_in       input syncs (polarity per SYNC_LOW) and display enable
//   r_in/g_in/b_in          input colour, DW bits per component
//   hs_out/vs_out/de_out    syncs and DE delayed to match colour
//   r_out/g_out/b_out       output colour
module scanlines_ext #(
   parameter int DW       = 6,
   parameter bit SYNC_LOW = 1'b1
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ce_pix,
   input  logic [1:0]    scanlines,
   input  logic [1:0]    period,
   input  logic          phase,
   input  logic          hs_in,
   input  logic          vs_in,
   input  logic          de_in,
   input  logic [DW-1:0] r_in,
   input  logic [DW-1:0] g_in,
   input  logic [DW-1:0] b_in,
   output logic          hs_out,
   output logic          vs_out,
   output logic          de_out,
   output logic [DW-1:0] r_out,
   output logic [DW-1:0] g_out,
   output logic [DW-1:0] b_out
);

   // Shadow configuration, only updated at reset or a vsync leading edge so a
   // mid-frame change never splits a frame between two settings.
   logic [1:0] lvl_s;
   logic [1:0] per_s;
   logic       ph_s;

   logic [1:0] line_cnt;

   // Previous raw sync samples (taken on ce_pix); reset to the inactive level.
   logic hs_p;
   logic vs_p;

   // Active-high views of current and previous syncs.
   logic hs_a, vs_a, hs_pa, vs_pa;
   logic hs_rise, vs_rise;

   assign hs_a    = hs_in ^ SYNC_LOW;
   assign vs_a    = vs_in ^ SYNC_LOW;
   assign hs_pa   = hs_p  ^ SYNC_LOW;
   assign vs_pa   = vs_p  ^ SYNC_LOW;
   assign hs_rise = hs_a & ~hs_pa;
   assign vs_rise = vs_a & ~vs_pa;

   // Last count value of a group (N-1); period 00 and 01 both mean every 2nd line.
   logic [1:0] last_cnt;

   always_comb begin
      last_cnt = 2'd1;
      case (per_s)
         2'b10:   last_cnt = 2'd2;
         2'b11:   last_cnt = 2'd3;
         default: last_cnt = 2'd1;
      endcase
   end

   // phase=1 dims the first line of each group, phase=0 the last.
   logic [1:0] dim_cnt;
   logic       dim;

   assign dim_cnt = ph_s ? 2'd0 : last_cnt;
   assign dim     = (lvl_s != 2'b00) && (line_cnt == dim_cnt);

   // Per-component darkening. (x>>1)+(x>>2) is at most 3/4 of full scale, so
   // the DW-bit sum cannot overflow.
   function automatic logic [DW-1:0] shade(input logic [DW-1:0] x,
                                           input logic [1:0]    lvl);
      logic [DW-1:0] y;
      case (lvl)
         2'b01:   y = (x >> 1) + (x >> 2);
         2'b10:   y = x >> 1;
         2'b11:   y = x >> 2;
         default: y = x;
      endcase
      return y;
   endfunction

   function automatic logic [DW-1:0] pix(input logic [DW-1:0] x,
                                         input logic          en,
                                         input logic          dm,
                                         input logic [1:0]    lvl);
      logic [DW-1:0] y;
      if (!en)
         y = '0;
      else if (dm)
         y = shade(x, lvl);
      else
         y = x;
      return y;
   endfunction

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         lvl_s    <= scanlines;
         per_s    <= period;
         ph_s     <= phase;
         line_cnt <= 2'd0;
         hs_p     <= SYNC_LOW;
         vs_p     <= SYNC_LOW;
         hs_out   <= SYNC_LOW;
         vs_out   <= SYNC_LOW;
         de_out   <= 1'b0;
         r_out    <= '0;
         g_out    <= '0;
         b_out    <= '0;
      end else if (ce_pix) begin
         hs_p <= hs_in;
         vs_p <= vs_in;

         // vsync has priority over hsync; during vsync hs pulses are ignored.
         if (vs_rise) begin
            line_cnt <= 2'd0;
            lvl_s    <= scanlines;
            per_s    <= period;
            ph_s     <= phase;
         end else if (vs_a) begin
            line_cnt <= 2'd0;
         end else if (hs_rise) begin
            if (line_cnt >= last_cnt)
               line_cnt <= 2'd0;
            else
               line_cnt <= line_cnt + 2'd1;
         end

         // Colour uses the count/config in force for the current pixel.
         hs_out <= hs_in;
         vs_out <= vs_in;
         de_out <= de_in;
         r_out  <= pix(r_in, de_in, dim, lvl_s);
         g_out  <= pix(g_in, de_in, dim, lvl_s);
         b_out  <= pix(b_in, de_in, dim, lvl_s);
      end
   end

endmodule
